// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: square clock, one-cycle tick or PWM on clk_50.
// New settings are shadowed and only switch over on a period boundary (or while stalled).
module clk_div_prog #(
  parameter int CNT_W        = 24,
  parameter int DEFAULT_DIV  = 6_250_000,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_ld,
  input  logic [CNT_W-1:0] div_val,
  input  logic [CNT_W-1:0] duty_val,
  input  logic [1:0]       mode_val,
  output logic             clk_out,
  output logic             tick,
  output logic             upd_ack,
  output logic             busy
);

  localparam logic [1:0]       MODE_TOGGLE = 2'd0;
  localparam logic [1:0]       MODE_PULSE  = 2'd1;
  localparam logic [1:0]       MODE_PWM    = 2'd2;
  localparam logic [1:0]       MODE_RSVD   = 2'd3;
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DIV_RST     = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DUTY_RST    = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [1:0]       MODE_RST    = 2'(DEFAULT_MODE);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] p_r;
  logic [CNT_W-1:0] d_r;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] sh_p_r;
  logic [CNT_W-1:0] sh_d_r;
  logic [1:0]       sh_mode_r;
  logic             busy_r;
  logic             clk_out_r;
  logic             tick_r;
  logic             upd_ack_r;

  logic [CNT_W-1:0] pe_s;
  logic             tc_s;
  logic             apply_s;
  logic [CNT_W-1:0] new_p_s;
  logic [CNT_W-1:0] new_d_s;
  logic [1:0]       new_mode_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             clk_nxt_s;

  // Period boundary detection, apply decision and next counter/output values
  always_comb begin
    pe_s    = (p_r == CNT_ZERO) ? CNT_ONE : p_r;
    tc_s    = en && (cnt_r == (pe_s - CNT_ONE));
    // A strobe landing exactly on the boundary bypasses the shadow so it applies right now
    apply_s = (tc_s && (busy_r || div_ld)) || (busy_r && !en);

    if (div_ld) begin
      new_p_s    = div_val;
      new_d_s    = duty_val;
      new_mode_s = mode_val;
    end else begin
      new_p_s    = sh_p_r;
      new_d_s    = sh_d_r;
      new_mode_s = sh_mode_r;
    end

    if (apply_s) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (!en) begin
      cnt_nxt_s = cnt_r;
    end else if (tc_s) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end

    clk_nxt_s = 1'b0;
    if (apply_s) begin
      if (new_mode_s == MODE_PWM) begin
        clk_nxt_s = (new_d_s != CNT_ZERO);
      end else begin
        clk_nxt_s = 1'b0;
      end
    end else if (!en) begin
      clk_nxt_s = clk_out_r;
    end else begin
      case (mode_r)
        MODE_TOGGLE: clk_nxt_s = clk_out_r ^ tc_s;
        MODE_PWM:    clk_nxt_s = (cnt_nxt_s < d_r);
        MODE_PULSE,
        MODE_RSVD:   clk_nxt_s = 1'b0;
        default:     clk_nxt_s = 1'b0;
      endcase
    end
  end

  // Counter, registered outputs and load-pending flag
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= CNT_ZERO;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
      upd_ack_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      clk_out_r <= clk_nxt_s;
      tick_r    <= tc_s;
      upd_ack_r <= apply_s;
      if (apply_s) begin
        busy_r <= 1'b0;
      end else if (div_ld) begin
        busy_r <= 1'b1;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  // Shadow capture on strobe and active settings update on apply
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      p_r       <= DIV_RST;
      d_r       <= DUTY_RST;
      mode_r    <= MODE_RST;
      sh_p_r    <= DIV_RST;
      sh_d_r    <= DUTY_RST;
      sh_mode_r <= MODE_RST;
    end else begin
      if (div_ld) begin
        sh_p_r    <= div_val;
        sh_d_r    <= duty_val;
        sh_mode_r <= mode_val;
      end
      if (apply_s) begin
        p_r    <= new_p_s;
        d_r    <= new_d_s;
        mode_r <= new_mode_s;
      end
    end
  end

  assign clk_out = clk_out_r;
  assign tick    = tick_r;
  assign upd_ack = upd_ack_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random loads,
// checked against a period-level behavioural model.
module tb_clk_div_prog;
  localparam int W       = 8;
  localparam int DEF_DIV = 4;

  logic         clk_50 = 1'b0;
  logic         rst_n, en, div_ld;
  logic [W-1:0] div_val, duty_val;
  logic [1:0]   mode_val;
  logic         clk_out, tick, upd_ack, busy;

  int checks   = 0;
  int failures = 0;

  clk_div_prog #(.CNT_W(W), .DEFAULT_DIV(DEF_DIV), .DEFAULT_MODE(0)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .en(en), .div_ld(div_ld),
    .div_val(div_val), .duty_val(duty_val), .mode_val(mode_val),
    .clk_out(clk_out), .tick(tick), .upd_ack(upd_ack), .busy(busy)
  );

  always #5 clk_50 = ~clk_50;

  // Reference model: position inside the period, completed-period count and pending load
  int m_p, m_d, m_mode, m_pos, m_periods;
  bit pend;
  int pend_p, pend_d, pend_mode;
  bit m_clk, m_tick, m_ack, m_busy;
  bit at_end, do_apply;

  function automatic int eff(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  always @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      m_p = DEF_DIV; m_d = DEF_DIV / 2; m_mode = 0; pend = 0;
      m_pos = 0; m_periods = 0;
      m_clk = 0; m_tick = 0; m_ack = 0; m_busy = 0;
    end else begin
      at_end   = en && (m_pos == eff(m_p) - 1);
      do_apply = (at_end && (pend || div_ld)) || (pend && !en);
      m_tick   = at_end;
      m_ack    = do_apply;
      if (do_apply) begin
        if (div_ld) begin
          m_p = div_val; m_d = duty_val; m_mode = mode_val;
        end else begin
          m_p = pend_p; m_d = pend_d; m_mode = pend_mode;
        end
        pend = 0; m_pos = 0; m_periods = 0;
      end else begin
        if (div_ld) begin
          pend = 1; pend_p = div_val; pend_d = duty_val; pend_mode = mode_val;
        end
        if (at_end) begin
          m_pos = 0; m_periods++;
        end else if (en) begin
          m_pos++;
        end
      end
      m_busy = pend;
      if (do_apply || en)
        m_clk = (m_mode == 0) ? (m_periods % 2 == 1) : (m_mode == 2) ? (m_pos < m_d) : 1'b0;
    end
  end

  logic [3:0] dut_o, mod_o;
  assign dut_o = {clk_out, tick, upd_ack, busy};
  assign mod_o = {m_clk, m_tick, m_ack, m_busy};

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; div_ld = 1'b0; div_val = '0; duty_val = '0; mode_val = 2'd0;
    #23;
    checks++;
    if (dut_o !== 4'b0000) begin failures++; $display("FAIL reset_outputs got=%b exp=0000", dut_o); end
    @(negedge clk_50); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50); checks++;
      if (dut_o !== 4'b0000) begin failures++; $display("FAIL idle_after_reset got=%b exp=0000", dut_o); end
    end
  endtask

  task automatic test_toggle();
    int first_tick = -1, last_tog = 0;
    bit prev = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_50); checks++;
      if (dut_o !== mod_o) begin failures++; $display("FAIL toggle_model t=%0t got=%b exp=%b", $time, dut_o, mod_o); end
      if (tick && first_tick < 0) first_tick = i;
      if (clk_out !== prev) begin
        if (last_tog != 0) begin
          checks++;
          if (i - last_tog != 4) begin failures++; $display("FAIL toggle_half got=%0d exp=4", i - last_tog); end
        end
        last_tog = i; prev = clk_out;
      end
    end
    checks++;
    if (first_tick != 4) begin failures++; $display("FAIL first_tick got=%0d exp=4", first_tick); end
  endtask

  task automatic test_reload();
    int ack_i = -1, last_tog = 0, k = 0;
    bit prev;
    while (m_pos != 1 && k < 20) begin @(negedge clk_50); k++; end
    checks++;
    if (m_pos != 1) begin failures++; $display("FAIL reload_wait got=%0d exp=1", m_pos); end
    prev = clk_out;
    div_ld = 1'b1; div_val = 8'd2; duty_val = 8'd1; mode_val = 2'd0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk_50); div_ld = 1'b0; checks++;
      if (dut_o !== mod_o) begin failures++; $display("FAIL reload_model t=%0t got=%b exp=%b", $time, dut_o, mod_o); end
      if (i <= 2) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL reload_busy got=%b exp=1", busy); end
      end
      if (upd_ack && ack_i < 0) ack_i = i;
      if (clk_out !== prev) begin
        if (last_tog != 0) begin
          checks++;
          if (ack_i > 0 && last_tog >= ack_i) begin
            if (i - last_tog != 2) begin failures++; $display("FAIL reload_half_new got=%0d exp=2", i - last_tog); end
          end else if (i - last_tog < 4) begin
            failures++; $display("FAIL reload_half_old got=%0d exp>=4", i - last_tog);
          end
        end
        last_tog = i; prev = clk_out;
      end
    end
    checks++;
    if (ack_i != 3) begin failures++; $display("FAIL reload_ack_cycle got=%0d exp=3", ack_i); end
  endtask

  task automatic test_pwm();
    int duties[3] = '{3, 0, 12};
    int highs_exp[3] = '{3, 0, 10};
    for (int s = 0; s < 3; s++) begin
      int highs = 0;
      bit got = 1'b0;
      @(negedge clk_50);
      div_ld = 1'b1; div_val = 8'd10; duty_val = 8'(duties[s]); mode_val = 2'd2;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk_50); div_ld = 1'b0; checks++;
        if (dut_o !== mod_o) begin failures++; $display("FAIL pwm_model t=%0t got=%b exp=%b", $time, dut_o, mod_o); end
        got = upd_ack;
      end
      checks++;
      if (!got) begin failures++; $display("FAIL pwm_ack_timeout got=0 exp=1"); end
      for (int i = 0; i < 10; i++) begin
        if (i > 0) begin
          @(negedge clk_50); checks++;
          if (dut_o !== mod_o) begin failures++; $display("FAIL pwm_model t=%0t got=%b exp=%b", $time, dut_o, mod_o); end
        end
        if (clk_out) highs++;
      end
      checks++;
      if (highs != highs_exp[s]) begin failures++; $display("FAIL pwm_duty d=%0d got=%0d exp=%0d", duties[s], highs, highs_exp[s]); end
    end
  endtask

  task automatic test_pulse_clamp();
    bit got = 1'b0;
    @(negedge clk_50);
    div_ld = 1'b1; div_val = 8'd0; duty_val = 8'd0; mode_val = 2'd1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk_50); div_ld = 1'b0; got = upd_ack;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL pulse_ack_timeout got=0 exp=1"); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({clk_out, tick} !== 2'b01) begin failures++; $display("FAIL pulse_clamp got=%b exp=01", {clk_out, tick}); end
      @(negedge clk_50);
    end
  endtask

  task automatic test_double_load();
    int acks = 0, ack_i = -1, last_tog = 0, k = 0;
    bit prev, got = 1'b0;
    div_ld = 1'b1; div_val = 8'd12; duty_val = 8'd0; mode_val = 2'd0;
    for (int j = 0; j < 10 && !got; j++) begin
      @(negedge clk_50); div_ld = 1'b0; got = upd_ack;
    end
    while (m_pos != 1 && k < 20) begin @(negedge clk_50); k++; end
    div_ld = 1'b1; div_val = 8'd6;
    @(negedge clk_50); div_val = 8'd3;
    prev = clk_out;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_50); div_ld = 1'b0; checks++;
      if (dut_o !== mod_o) begin failures++; $display("FAIL dbl_model t=%0t got=%b exp=%b", $time, dut_o, mod_o); end
      if (upd_ack) begin acks++; if (ack_i < 0) ack_i = i; end
      if (clk_out !== prev) begin
        if (ack_i > 0 && last_tog >= ack_i) begin
          checks++;
          if (i - last_tog != 3) begin failures++; $display("FAIL dbl_half got=%0d exp=3", i - last_tog); end
        end
        last_tog = i; prev = clk_out;
      end
    end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL dbl_ack_count got=%0d exp=1", acks); end
    k = 0;
    while (m_pos != eff(m_p) - 1 && k < 20) begin @(negedge clk_50); k++; end
    div_ld = 1'b1; div_val = 8'd5; mode_val = 2'd0;
    @(negedge clk_50); div_ld = 1'b0; checks++;
    if ({upd_ack, busy} !== 2'b10) begin failures++; $display("FAIL coincident_ack got=%b exp=10", {upd_ack, busy}); end
  endtask

  task automatic test_en_hold();
    int k = 0, held_pos, exp_wait, wait_n = 0;
    bit held_clk, got = 1'b0;
    while (m_pos != 2 && k < 20) begin @(negedge clk_50); k++; end
    held_pos = m_pos; held_clk = clk_out; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50); checks++;
      if ({clk_out, tick} !== {held_clk, 1'b0}) begin failures++; $display("FAIL en_hold got=%b exp=%b", {clk_out, tick}, {held_clk, 1'b0}); end
    end
    exp_wait = eff(m_p) - held_pos;
    en = 1'b1;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk_50); got = tick; wait_n = i;
    end
    checks++;
    if (!got || wait_n != exp_wait) begin failures++; $display("FAIL en_resume got=%0d exp=%0d", wait_n, exp_wait); end
    en = 1'b0; div_ld = 1'b1; div_val = 8'd7; mode_val = 2'd0;
    @(negedge clk_50); div_ld = 1'b0; checks++;
    if ({upd_ack, busy} !== 2'b01) begin failures++; $display("FAIL en0_load_busy got=%b exp=01", {upd_ack, busy}); end
    @(negedge clk_50); checks++;
    if ({upd_ack, busy} !== 2'b10) begin failures++; $display("FAIL en0_load_ack got=%b exp=10", {upd_ack, busy}); end
    en = 1'b1;
    repeat (10) @(negedge clk_50);
    @(posedge clk_50); #2 rst_n = 1'b0; #1 checks++;
    if (dut_o !== 4'b0000) begin failures++; $display("FAIL async_reset got=%b exp=0000", dut_o); end
    @(negedge clk_50); rst_n = 1'b1;
    got = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk_50); got = tick; wait_n = i;
    end
    checks++;
    if (!got || wait_n != DEF_DIV) begin failures++; $display("FAIL reset_default_div got=%0d exp=%0d", wait_n, DEF_DIV); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_50); checks++;
      if (dut_o !== mod_o) begin failures++; $display("FAIL random_model t=%0t got=%b exp=%b", $time, dut_o, mod_o); end
      en       = ($urandom_range(0, 9) != 0);
      div_ld   = ($urandom_range(0, 11) == 0);
      div_val  = 8'($urandom_range(0, 9));
      duty_val = 8'($urandom_range(0, 12));
      mode_val = 2'($urandom_range(0, 3));
    end
    div_ld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_reload();
    test_pwm();
    test_pulse_clamp();
    test_double_load();
    test_en_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
